muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
//   - Takes the same rs/rt operands the ALU receives.
//   - Executes MULT/MULTU/DIV/DIVU iteratively and holds the architectural HI/LO registers.
//   - Drives busy so the hazard unit stalls the pipe while an operation is in flight.
//   - hi/lo feed the MFHI/MFLO writeback path.
// PARAMETERS
//   WORD_WIDTH  32  operand and HI/LO width; iteration count equals WORD_WIDTH
// PORTS
//   clk    in   1           clock; every register updates on the rising edge
//   rst    in   1           synchronous, active-high reset
//   start  in   1           request; sampled only in IDLE
//   op     in   3           000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   inA    in   WORD_WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
//   inB    in   WORD_WIDTH  rt operand (multiplier / divisor)
//   flush  in   1           abort the in-flight operation (branch or exception squash)
//   busy   out  1           1 while state != IDLE
//   done   out  1           one-cycle pulse: a MUL/DIV result has just been committed to hi/lo
//   hi     out  WORD_WIDTH  HI register
//   lo     out  WORD_WIDTH  LO register
// BEHAVIOUR
//   Reset
//     - rst=1 at any edge (including mid-operation) forces state=IDLE, counter=0, busy=0,
//       done=0, hi=0, lo=0; the in-flight operation is discarded.
//   States IDLE -> CALC -> FIX -> IDLE
//     IDLE, start=1, flush=0:
//       - MULT/MULTU/DIV/DIVU: latch |inA| and |inB| (signed ops) or the raw values (unsigned).
//         Latch the result signs: quotient/product sign = signA^signB; remainder sign = signA.
//         Clear counter; go to CALC.
//       - MTHI/MTLO: hi<=inA or lo<=inA at that edge; stay in IDLE; no done pulse.
//       - NOP or an undefined op (111): no effect.
//     CALC (exactly WORD_WIDTH cycles; counter runs 0..WORD_WIDTH-1):
//       - Multiply: shift-add one multiplier bit per cycle into a 2*WORD_WIDTH accumulator.
//       - Divide: restoring division, one quotient bit per cycle.
//       - Leave for FIX when counter == WORD_WIDTH-1.
//     FIX (1 cycle):
//       - Apply the latched signs (two's-complement negate).
//       - Multiply: {hi,lo} <= 2W-bit product.
//       - Divide: lo <= quotient, hi <= remainder.
//       - Go to IDLE; done <= 1 for the following cycle only.
//   Latency
//     - Start accepted at edge E: busy=1 for cycles E+1 .. E+W+1.
//     - At edge E+W+2: busy=0, done=1, and hi/lo already hold the new result.
//   Boundary rules
//     - start while busy: ignored; hi/lo untouched. The hazard unit must hold the instruction.
//     - Divide by zero (DIV or DIVU): full latency; result lo = all ones, hi = inA as latched raw.
//     - DIV of 0x80000000 by -1: lo = 0x80000000, hi = 0 (truncated wrap, no trap).
//     - flush=1 in CALC or FIX: IDLE at the next edge; hi/lo keep their prior values; no done pulse.
//     - flush=1 together with start in IDLE: flush wins; the request is ignored (including MTHI/MTLO).
//     - rst and flush together: rst wins.
//     - No overflow is flagged on any operation.
// TESTING
//   1. MULT inA=-3 (0xFFFFFFFD), inB=7 -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
//   3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
//   4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//      Then MTHI 0x1234 -> hi=0x1234 next edge, done stays 0.
//   5. Start DIVU; pulse start with MTLO at cycle 5 -> ignored.
//      Flush at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//   6. Start MULT; assert rst at cycle 12 -> next cycle busy=0, hi=lo=0.
//      A new MULTU 5x6 then yields lo=30, hi=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side drives the request; the unit returns status and the HI/LO registers.
interface muldiv_unit_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [WORD_WIDTH-1:0] inA;
    logic [WORD_WIDTH-1:0] inB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] hi;
    logic [WORD_WIDTH-1:0] lo;

    modport master (
        output start, op, inA, inB, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Magnitudes are processed one bit per cycle; signs are re-applied in a single fix-up cycle.
module muldiv_unit #(
    parameter int WORD_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_unit_if.slave    bus
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    // Datapath: accumulator, step operand and the latched operation attributes.
    logic [2*W-1:0]  acc;
    logic [W-1:0]    opb;
    logic [W-1:0]    raw_a;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;

    op_t             op_in;
    logic            op_signed;
    logic            op_div;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_diff;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix;
    logic [W-1:0]    rem_fix;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_in     = op_t'(bus.op);
        op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
        op_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
        a_neg     = op_signed & bus.inA[W-1];
        b_neg     = op_signed & bus.inB[W-1];
        a_abs     = a_neg ? -bus.inA : bus.inA;
        b_abs     = b_neg ? -bus.inB : bus.inB;

        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
        rem_sh    = {acc[2*W-1:W], acc[W-1]};
        rem_diff  = rem_sh - {1'b0, opb};

        acc_next  = acc;
        if (is_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (rem_diff[W])
                acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
            else
                acc_next = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[W-1:1]};
        end

        prod_fix  = neg_q ? -acc : acc;
        quot_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rem_fix   = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    // NOTE: state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: acc/opb/raw_a and the sign flags are left unreset; they are rewritten on every accepted start.
            state   <= IDLE;
            counter <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (op_in)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div  <= op_div;
                                neg_q   <= a_neg ^ b_neg;
                                neg_r   <= a_neg;
                                raw_a   <= bus.inA;
                                opb     <= op_div ? b_abs : a_abs;
                                acc     <= {{W{1'b0}}, (op_div ? a_abs : b_abs)};
                                counter <= '0;
                                busy_q  <= 1'b1;
                                state   <= CALC;
                            end
                            OP_MTHI: hi_q <= bus.inA;
                            OP_MTLO: lo_q <= bus.inA;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc     <= acc_next;
                        counter <= counter + CW'(1);
                        if (counter == CW'(W - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (!is_div) begin
                            hi_q <= prod_fix[2*W-1:W];
                            lo_q <= prod_fix[W-1:0];
                        end else if (opb == '0) begin
                            hi_q <= raw_a;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
